// File: rtl/operand_loader.sv
// Operand entry front end: sync + debounce two bouncy keys, FSM latches sw into a then b.
// Press updates outputs on edge DEBOUNCE_CYCLES+2 after the key goes low; no backpressure, outputs are registered.
module operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   input  logic       key_load_n,
   input  logic       key_clr_n,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic       valid,
   output logic [1:0] phase
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned KEY_LOAD = 0;
   localparam int unsigned KEY_CLR  = 1;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      READY  = 2'b10
   } phase_t;

   logic [1:0] key_meta;
   logic [1:0] key_sync;
   logic [3:0] sw_meta;
   logic [3:0] sw_sync;
   logic [1:0] key_press;
   phase_t     state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 2'b11;
         key_sync <= 2'b11;
         sw_meta  <= 4'd0;
         sw_sync  <= 4'd0;
      end else begin
         key_meta <= {key_clr_n, key_load_n};
         key_sync <= key_meta;
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
      end
   end

   // The press strobe is taken from the flip decision itself so the FSM
   // moves on the same edge as the debounced level.
   for (genvar k = 0; k < 2; k++) begin : g_deb
      logic          level;
      logic [CW-1:0] cnt;
      logic          differ;
      logic          expire;

      assign differ       = key_sync[k] != level;
      assign expire       = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
      assign key_press[k] = expire && level;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
         end else if (!differ) begin
            cnt <= '0;
         end else if (expire) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD_A;
         a     <= 4'd0;
         b     <= 4'd0;
         valid <= 1'b0;
      end else if (key_press[KEY_CLR]) begin
         state <= LOAD_A;
         a     <= 4'd0;
         b     <= 4'd0;
         valid <= 1'b0;
      end else if (key_press[KEY_LOAD]) begin
         case (state)
            LOAD_A: begin
               a     <= sw_sync;
               valid <= 1'b0;
               state <= LOAD_B;
            end
            LOAD_B: begin
               b     <= sw_sync;
               valid <= 1'b1;
               state <= READY;
            end
            READY: begin
               a     <= sw_sync;
               valid <= 1'b0;
               state <= LOAD_B;
            end
            default: begin
               state <= LOAD_A;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign phase = state;

endmodule
